// File: rtl/jit_pkg.sv
// Shared constants, command/status layouts and FSM encoding for the jit command sequencer.
package jit_pkg;

  localparam int unsigned CMD_W = 32;

  localparam logic [3:0]  CMD_TYPEA    = 4'hA;
  localparam logic [3:0]  CMD_TYPEB    = 4'hB;
  localparam logic [3:0]  CMD_TYPEC    = 4'hC;
  localparam logic [15:0] DONE_MAGIC   = 16'hBABE;
  localparam logic [3:0]  STAT_OK      = 4'h0;
  localparam logic [3:0]  STAT_TIMEOUT = 4'h1;
  localparam logic [7:0]  STATUS_TAG   = 8'hD0;
  localparam logic [7:0]  ERR_MAX      = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_REPORT
  } seq_state_e;

  // Host command word layout
  typedef struct packed {
    logic [3:0]  cls;
    logic [3:0]  acc_id;
    logic [7:0]  rsvd;
    logic [15:0] tag;
  } cmd_t;

  // Status word posted back to the host
  typedef struct packed {
    logic [7:0]  marker;
    logic [3:0]  status;
    logic [3:0]  acc_id;
    logic [15:0] tag;
  } status_t;

  // Start commands need a real accelerator id; B/C pass with any id
  function automatic logic cmd_legal(input cmd_t c, input int unsigned num_accs);
    return (c.cls == CMD_TYPEB) || (c.cls == CMD_TYPEC) ||
           ((c.cls == CMD_TYPEA) && (c.acc_id != 4'h0) && (32'(c.acc_id) <= num_accs));
  endfunction

endpackage

// File: rtl/jit_cmd_fifo.sv
// Synchronous show-ahead FIFO holding host command words until the sequencer pops them.
module jit_cmd_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW-1:0]    wr_ptr_d, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_wr, do_rd;

  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign do_wr     = wr_en_i && !full_o;
  assign do_rd     = rd_en_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance; the extra MSB distinguishes full from empty
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + PW'(1);
  end

  // Pointer registers; reset flushes the contents
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array, written at the write pointer
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/jit_cmd_sequencer.sv
// Buffers host commands, issues them one at a time to dispatch and reports start-run completion.
module jit_cmd_sequencer
  import jit_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned NUM_ACCs       = 2
) (
  input  logic        ACLK,
  input  logic        ARESET,
  output logic        sH_tready,
  input  logic        sH_tvalid,
  input  logic [31:0] sH_tdata,
  input  logic        mD_tready,
  output logic        mD_tvalid,
  output logic [31:0] mD_tdata,
  output logic        sD_tready,
  input  logic        sD_tvalid,
  input  logic [31:0] sD_tdata,
  input  logic        mH_tready,
  output logic        mH_tvalid,
  output logic [31:0] mH_tdata,
  output logic        BUSY,
  output logic        TIMEOUT,
  output logic [7:0]  ERR_CNT
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  seq_state_e    state_q, state_d;
  cmd_t          rcmd_q, rcmd_d;
  logic [3:0]    status_q, status_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    err_q, err_d;
  logic          timeout_q, timeout_d;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CMD_W-1:0] fifo_rdata;
  logic          drop_err, stray_err, wait_match;
  logic [1:0]    err_inc;
  logic [8:0]    err_sum;
  status_t       status_word;

  assign sH_tready = !ARESET && !fifo_full;
  assign fifo_push = sH_tvalid && sH_tready;

  jit_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk_i     (ACLK),
    .rst_i     (ARESET),
    .wr_en_i   (fifo_push),
    .wr_data_i (sH_tdata),
    .rd_en_i   (fifo_pop),
    .rd_data_o (fifo_rdata),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Next-state, pop/error strobes and counter updates
  always_comb begin
    state_d    = state_q;
    rcmd_d     = rcmd_q;
    status_d   = status_q;
    timer_d    = timer_q;
    timeout_d  = timeout_q;
    fifo_pop   = 1'b0;
    drop_err   = 1'b0;
    wait_match = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          rcmd_d   = cmd_t'(fifo_rdata);
          if (cmd_legal(cmd_t'(fifo_rdata), NUM_ACCs)) state_d = ST_ISSUE;
          else                                         drop_err = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (mD_tready) begin
          if (rcmd_q.cls == CMD_TYPEA) begin
            state_d = ST_WAIT;
            timer_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_WAIT: begin
        wait_match = sD_tvalid && (sD_tdata == {DONE_MAGIC, 12'h000, rcmd_q.acc_id});
        if (wait_match) begin
          state_d  = ST_REPORT;
          status_d = STAT_OK;
        end else if (timer_q == TIMER_LAST) begin
          state_d   = ST_REPORT;
          status_d  = STAT_TIMEOUT;
          timeout_d = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_REPORT: begin
        if (mH_tready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Any completion word not consumed as the awaited match is an error
    stray_err = sD_tvalid && !wait_match;
    err_inc   = {1'b0, drop_err} + {1'b0, stray_err};
    err_sum   = {1'b0, err_q} + {7'b0, err_inc};
    err_d     = err_sum[8] ? ERR_MAX : err_sum[7:0];
  end

  // State and datapath registers
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= ST_IDLE;
      rcmd_q    <= '0;
      status_q  <= '0;
      timer_q   <= '0;
      err_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rcmd_q    <= rcmd_d;
      status_q  <= status_d;
      timer_q   <= timer_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
    end
  end

  assign status_word = '{marker: STATUS_TAG, status: status_q, acc_id: rcmd_q.acc_id,
                         tag: rcmd_q.tag};

  // Outputs decode registered state and are forced low while reset is held
  assign sD_tready = !ARESET;
  assign mD_tvalid = !ARESET && (state_q == ST_ISSUE);
  assign mD_tdata  = ARESET ? '0 : rcmd_q;
  assign mH_tvalid = !ARESET && (state_q == ST_REPORT);
  assign mH_tdata  = ARESET ? '0 : status_word;
  assign BUSY      = !ARESET && ((state_q != ST_IDLE) || !fifo_empty);
  assign TIMEOUT   = !ARESET && timeout_q;
  assign ERR_CNT   = ARESET ? '0 : err_q;

endmodule

// File: tb/tb_jit_cmd_sequencer.sv
// Directed and randomized checks of jit_cmd_sequencer against a transaction-level model.
module tb_jit_cmd_sequencer;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned TO    = 16;
  localparam int unsigned NACC  = 2;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        sH_tready, sH_tvalid;
  logic [31:0] sH_tdata;
  logic        mD_tready, mD_tvalid;
  logic [31:0] mD_tdata;
  logic        sD_tready, sD_tvalid;
  logic [31:0] sD_tdata;
  logic        mH_tready, mH_tvalid;
  logic [31:0] mH_tdata;
  logic        BUSY, TIMEOUT;
  logic [7:0]  ERR_CNT;

  always #5 ACLK = ~ACLK;

  jit_cmd_sequencer #(
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TO),
    .NUM_ACCs       (NACC)
  ) dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .sH_tready (sH_tready),
    .sH_tvalid (sH_tvalid),
    .sH_tdata  (sH_tdata),
    .mD_tready (mD_tready),
    .mD_tvalid (mD_tvalid),
    .mD_tdata  (mD_tdata),
    .sD_tready (sD_tready),
    .sD_tvalid (sD_tvalid),
    .sD_tdata  (sD_tdata),
    .mH_tready (mH_tready),
    .mH_tvalid (mH_tvalid),
    .mH_tdata  (mH_tdata),
    .BUSY      (BUSY),
    .TIMEOUT   (TIMEOUT),
    .ERR_CNT   (ERR_CNT)
  );

  int checks = 0;
  int errors = 0;
  int md_hs  = 0;
  int mh_hs  = 0;
  logic [31:0] exp_md[$];
  logic [31:0] exp_mh[$];
  int   exp_err = 0;
  logic exp_to  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Model: which host words reach dispatch
  function automatic bit legal(input logic [31:0] w);
    logic [3:0] c;
    logic [3:0] id;
    c  = w[31:28];
    id = w[27:24];
    return (c == 4'hB) || (c == 4'hC) ||
           (c == 4'hA && int'(id) >= 1 && int'(id) <= int'(NACC));
  endfunction

  function automatic int sat(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  // Handshake monitor: every transfer must match the next expected word
  always @(negedge ACLK) begin
    if (!ARESET) begin
      if (mD_tvalid && mD_tready) begin
        md_hs++;
        if (exp_md.size() == 0) chk("md_unexpected", 32'(exp_md.size()), 32'd1);
        else                    chk("md_word", mD_tdata, exp_md.pop_front());
      end
      if (mH_tvalid && mH_tready) begin
        mh_hs++;
        if (exp_mh.size() == 0) chk("mh_unexpected", 32'(exp_mh.size()), 32'd1);
        else                    chk("mh_word", mH_tdata, exp_mh.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_sH_tready"}, sH_tready, 0);
    chk({tag, "_mD_tvalid"}, mD_tvalid, 0);
    chk({tag, "_mD_tdata"},  mD_tdata,  0);
    chk({tag, "_sD_tready"}, sD_tready, 0);
    chk({tag, "_mH_tvalid"}, mH_tvalid, 0);
    chk({tag, "_mH_tdata"},  mH_tdata,  0);
    chk({tag, "_BUSY"},      BUSY,      0);
    chk({tag, "_TIMEOUT"},   TIMEOUT,   0);
    chk({tag, "_ERR_CNT"},   ERR_CNT,   0);
  endtask

  task automatic do_reset(input int cycles);
    ARESET = 1'b1;
    sH_tvalid = 1'b0; sH_tdata = '0;
    sD_tvalid = 1'b0; sD_tdata = '0;
    mH_tready = 1'b0; mD_tready = 1'b1;
    #1;
    chk_zero("rst_now");
    repeat (cycles) tick();
    chk_zero("rst_held");
    exp_md.delete();
    exp_mh.delete();
    exp_err = 0;
    exp_to  = 1'b0;
    ARESET = 1'b0;
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    int n;
    n = 0;
    sH_tvalid = 1'b1;
    sH_tdata  = w;
    while (!sH_tready && n < 100) begin
      tick();
      n++;
    end
    chk("push_ready", 32'(n < 100), 1);
    tick();
    sH_tvalid = 1'b0;
    if (legal(w)) exp_md.push_back(w);
    else          exp_err = sat(exp_err);
  endtask

  task automatic wait_md(input int target, input bit rbp);
    int n;
    n = 0;
    while (md_hs < target && n < 300) begin
      mD_tready = rbp ? ($urandom_range(0, 3) != 0) : 1'b1;
      tick();
      n++;
    end
    mD_tready = 1'b1;
    chk("md_wait", 32'(md_hs >= target), 1);
  endtask

  task automatic take_status();
    int n;
    int mh0;
    n   = 0;
    mh0 = mh_hs;
    while (!mH_tvalid && n < int'(TO) + 20) begin
      tick();
      n++;
    end
    repeat ($urandom_range(0, 3)) begin
      tick();
      chk("mh_hold", mH_tvalid, 1);
    end
    mH_tready = 1'b1;
    tick();
    mH_tready = 1'b0;
    chk("mh_done", mh_hs, mh0 + 1);
  endtask

  // Called right after the start command handshake: mode 0 good, 1 bad-then-good, 2 timeout
  task automatic do_a(input logic [31:0] w, input int mode, input int d, input bit late);
    logic [31:0] good;
    int n;
    good = {16'hBABE, 12'h000, w[27:24]};
    if (mode == 2) begin
      exp_mh.push_back({8'hD0, 4'h1, w[27:24], w[15:0]});
      exp_to = 1'b1;
      n = 0;
      while (!mH_tvalid && n < int'(TO) + 5) begin
        tick();
        n++;
      end
      chk("timeout_latency", n, TO);
    end else begin
      exp_mh.push_back({8'hD0, 4'h0, w[27:24], w[15:0]});
      repeat (d) tick();
      sD_tvalid = 1'b1;
      if (mode == 1) begin
        sD_tdata = good ^ (32'h1 << $urandom_range(0, 31));
        tick();
        exp_err = sat(exp_err);
      end
      sD_tdata = good;
      tick();
      sD_tvalid = 1'b0;
      sD_tdata  = '0;
      chk("resp_latency", mH_tvalid, 1);
    end
    take_status();
    chk("a_timeout_flag", TIMEOUT, exp_to);
    chk("a_busy", BUSY, 0);
    if (late) begin
      sD_tvalid = 1'b1;
      sD_tdata  = good;
      tick();
      sD_tvalid = 1'b0;
      sD_tdata  = '0;
      exp_err = sat(exp_err);
    end
    chk("a_err", ERR_CNT, exp_err);
  endtask

  task automatic run_cmd(input logic [31:0] w, input int mode, input int d, input bit late);
    int tgt;
    int mh0;
    tgt = md_hs + 1;
    mh0 = mh_hs;
    push(w);
    if (!legal(w)) begin
      tick();
      chk("drop_err", ERR_CNT, exp_err);
      chk("drop_busy", BUSY, 0);
      chk("drop_no_md", md_hs, tgt - 1);
    end else begin
      wait_md(tgt, 1'b1);
      if (w[31:28] == 4'hA) begin
        do_a(w, mode, d, late);
      end else begin
        chk("bc_busy", BUSY, 0);
        chk("bc_no_mh", mh_hs, mh0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    int md0;
    int mh0;
    int sel;
    int mode;

    do_reset(3);
    chk("post_rst_sH_tready", sH_tready, 1);
    chk("post_rst_busy", BUSY, 0);
    chk("post_rst_err", ERR_CNT, 0);

    // 1: start command, completion 3 cycles into the run
    md0 = md_hs;
    push(32'hA1000005);
    chk("t1_not_yet_valid", mD_tvalid, 0);
    tick();
    chk("t1_md_valid", mD_tvalid, 1);
    chk("t1_md_data", mD_tdata, 32'hA1000005);
    wait_md(md0 + 1, 1'b0);
    do_a(32'hA1000005, 0, 3, 1'b0);
    chk("t1_timeout_clear", TIMEOUT, 0);

    // 2: back-to-back B and C commands
    md0 = md_hs;
    mh0 = mh_hs;
    push(32'hB2000011);
    push(32'hC2001234);
    chk("t2_busy_mid", BUSY, 1);
    wait_md(md0 + 2, 1'b0);
    chk("t2_busy_end", BUSY, 0);
    chk("t2_no_mh", mh_hs, mh0);

    // 3: start command that never completes, then a late completion
    md0 = md_hs;
    push(32'hA2000007);
    wait_md(md0 + 1, 1'b0);
    do_a(32'hA2000007, 2, 0, 1'b1);
    chk("t3_err_one", ERR_CNT, 1);

    // 4: fill the FIFO behind a stalled dispatch, then drain in order
    md0 = md_hs;
    mD_tready = 1'b0;
    for (int i = 0; i < int'(DEPTH) + 1; i++) begin
      push({(i % 2 == 0) ? 4'hB : 4'hC, 4'(i), 8'h00, 16'(16'h0100 + i)});
    end
    chk("t4_full", sH_tready, 0);
    chk("t4_busy", BUSY, 1);
    chk("t4_no_issue", md_hs, md0);
    wait_md(md0 + int'(DEPTH) + 1, 1'b0);
    chk("t4_drained", BUSY, 0);
    chk("t4_ready_again", sH_tready, 1);

    // 5: illegal class and out-of-range accelerator id
    do_reset(2);
    md0 = md_hs;
    push(32'h51000000);
    push(32'hA9000000);
    tick();
    chk("t5_err", ERR_CNT, 2);
    chk("t5_no_md", md_hs, md0);
    chk("t5_busy", BUSY, 0);

    // 6: reset while waiting for completion
    md0 = md_hs;
    mh0 = mh_hs;
    push(32'hA1000042);
    wait_md(md0 + 1, 1'b0);
    repeat (3) tick();
    do_reset(2);
    repeat (TO + 4) tick();
    chk("t6_no_mh", mh_hs, mh0);
    chk("t6_idle", BUSY, 0);
    run_cmd(32'hA1000099, 0, 2, 1'b0);

    // Randomized command stream
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      w[31:28] = (sel < 5) ? 4'hA : (sel < 7) ? 4'hB : (sel < 8) ? 4'hC : 4'($urandom_range(0, 15));
      w[27:24] = 4'($urandom_range(0, 3));
      w[23:0]  = 24'($urandom);
      mode = $urandom_range(0, 2);
      run_cmd(w, mode, (mode == 1) ? $urandom_range(0, 14) : $urandom_range(0, 15),
              1'($urandom_range(0, 1)));
    end

    // Error counter saturation with stray completion words
    do_reset(2);
    sD_tvalid = 1'b1;
    sD_tdata  = 32'hBABE0001;
    repeat (254) begin
      tick();
      exp_err = sat(exp_err);
    end
    chk("sat_254", ERR_CNT, exp_err);
    tick();
    exp_err = sat(exp_err);
    chk("sat_255", ERR_CNT, 8'hFF);
    repeat (5) tick();
    chk("sat_hold", ERR_CNT, 8'hFF);
    sD_tvalid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
